// File: rtl/xaccum.sv
// xaccum: windowed stream reducer (ADD / MAX / MIN / LAST) over one flow-bus lane.
// The lane is picked by sel. Each window of 'period' samples produces one registered result.
// A run produces 'iterations' windows, after an optional start delay.
// Optional build macro: XACCUM_SAT_EN. When defined, ADD saturates to the signed limits;
// otherwise ADD wraps.

`ifndef DATABUS_W
`define DATABUS_W 256
`endif
`ifndef N_W
`define N_W 4
`endif

module xaccum #(
    parameter int DATA_W   = 32,
    parameter int PERIOD_W = 10,
    parameter int DELAY_W  = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    run,
    output logic                                    done,
    input  logic [2*`DATABUS_W-1:0]                 flow_in,
    output logic [DATA_W-1:0]                       flow_out,
    input  logic [`N_W+DELAY_W+2*PERIOD_W+2-1:0]    configdata
);
    localparam int CFG_W     = `N_W + DELAY_W + 2*PERIOD_W + 2;
    localparam int N_LANES   = 2*`DATABUS_W / DATA_W;
    localparam int SEL_SLOTS = 2**`N_W;

    localparam logic [1:0] M_ADD = 2'd0;
    localparam logic [1:0] M_MAX = 2'd1;
    localparam logic [1:0] M_MIN = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_ACC} state_t;

    // configuration fields, MSB first: sel, delay, period, iterations, mode
    logic [`N_W-1:0]     w_cfg_sel;
    logic [DELAY_W-1:0]  w_cfg_delay;
    logic [PERIOD_W-1:0] w_cfg_period;
    logic [PERIOD_W-1:0] w_cfg_iters;
    logic [1:0]          w_cfg_mode;

    assign w_cfg_sel    = configdata[CFG_W-1 -: `N_W];
    assign w_cfg_delay  = configdata[2*PERIOD_W+DELAY_W+1 -: DELAY_W];
    assign w_cfg_period = configdata[2*PERIOD_W+1 -: PERIOD_W];
    assign w_cfg_iters  = configdata[PERIOD_W+1 -: PERIOD_W];
    assign w_cfg_mode   = configdata[1:0];

    state_t              r_state, w_state_nxt;
    logic [`N_W-1:0]     r_sel;
    logic [1:0]          r_mode;
    logic [PERIOD_W-1:0] r_per_m1;   // effective period minus one (period 0 behaves as 1)
    logic [PERIOD_W-1:0] r_it_last;  // iterations minus one
    logic [DELAY_W-1:0]  r_dcnt;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] r_it;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_flow_out;

    // lane mux: unused select codes read as zero
    logic [DATA_W-1:0] w_lanes [SEL_SLOTS];
    logic [DATA_W-1:0] w_x;

    for (genvar g = 0; g < SEL_SLOTS; g++) begin : g_lane
        if (g < N_LANES) begin : g_on
            assign w_lanes[g] = flow_in[g*DATA_W +: DATA_W];
        end else begin : g_off
            assign w_lanes[g] = '0;
        end
    end

    // operand is taken straight from the bus; upstream latency is covered by delay
    assign w_x = w_lanes[r_sel];

    logic w_last_sample, w_last_iter;
    assign w_last_sample = (r_cnt == r_per_m1);
    assign w_last_iter   = (r_it == r_it_last);

    // adder, optionally saturating on signed overflow (carry into MSB != carry out of MSB)
    logic [DATA_W-1:0] w_add;
`ifdef XACCUM_SAT_EN
    logic [DATA_W:0] w_add_full;
    logic            w_c_msb_in, w_ovf;
    assign w_add_full = {1'b0, r_acc} + {1'b0, w_x};
    assign w_c_msb_in = w_add_full[DATA_W-1] ^ r_acc[DATA_W-1] ^ w_x[DATA_W-1];
    assign w_ovf      = w_c_msb_in ^ w_add_full[DATA_W];
    assign w_add      = !w_ovf ? w_add_full[DATA_W-1:0] :
                        r_acc[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`else
    assign w_add = r_acc + w_x;
`endif

    // signed compare on sign-extended operands
    logic signed [DATA_W:0] w_acc_ext, w_x_ext;
    logic                   w_acc_lt;
    assign w_acc_ext = {r_acc[DATA_W-1], r_acc};
    assign w_x_ext   = {w_x[DATA_W-1], w_x};
    assign w_acc_lt  = (w_acc_ext < w_x_ext);

    // next accumulator value; the first sample of a window discards history
    logic [DATA_W-1:0] w_op, w_acc_next;
    always_comb begin
        w_op = w_x;
        case (r_mode)
            M_ADD:   w_op = w_add;
            M_MAX:   w_op = w_acc_lt ? w_x : r_acc;
            M_MIN:   w_op = w_acc_lt ? r_acc : w_x;
            default: w_op = w_x;
        endcase
        w_acc_next = (r_cnt == '0) ? w_x : w_op;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // next-state and done
    always_comb begin
        w_state_nxt = r_state;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                done = 1'b1;
                if (run && (w_cfg_iters != '0))
                    w_state_nxt = (w_cfg_delay != '0) ? S_DELAY : S_ACC;
            end
            S_DELAY: if (r_dcnt == DELAY_W'(1)) w_state_nxt = S_ACC;
            S_ACC:   if (w_last_sample && w_last_iter) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // shadow config, counters, accumulator and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel      <= '0;
            r_mode     <= '0;
            r_per_m1   <= '0;
            r_it_last  <= '0;
            r_dcnt     <= '0;
            r_cnt      <= '0;
            r_it       <= '0;
            r_acc      <= '0;
            r_flow_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (run) begin
                    r_sel     <= w_cfg_sel;
                    r_mode    <= w_cfg_mode;
                    r_per_m1  <= (w_cfg_period == '0) ? '0 : w_cfg_period - PERIOD_W'(1);
                    r_it_last <= w_cfg_iters - PERIOD_W'(1);
                    r_dcnt    <= w_cfg_delay;
                    r_cnt     <= '0;
                    r_it      <= '0;
                end
                S_DELAY: r_dcnt <= r_dcnt - DELAY_W'(1);
                S_ACC: begin
                    r_acc <= w_acc_next;
                    if (w_last_sample) begin
                        r_flow_out <= w_acc_next;
                        r_cnt      <= '0;
                        r_it       <= r_it + PERIOD_W'(1);
                    end else begin
                        r_cnt <= r_cnt + PERIOD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign flow_out = r_flow_out;

endmodule

// File: tb/tb_xaccum.sv
// Bench for xaccum: directed cases with literal expectations and a randomized phase.
// All cases are checked every cycle against a window-level model built from a per-cycle
// bus history.

`ifndef DATABUS_W
`define DATABUS_W 256
`endif
`ifndef N_W
`define N_W 4
`endif

module tb_xaccum;
    localparam int DATA_W   = 32;
    localparam int PERIOD_W = 10;
    localparam int DELAY_W  = 8;
    localparam int BUS_W    = 2*`DATABUS_W;
    localparam int NW       = `N_W;
    localparam int CFG_W    = NW + DELAY_W + 2*PERIOD_W + 2;
    localparam int MAXC     = 8192;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              run = 1'b0;
    logic              done;
    logic [BUS_W-1:0]  flow_in = '0;
    logic [DATA_W-1:0] flow_out;
    logic [CFG_W-1:0]  configdata = '0;

    xaccum dut (
        .clk(clk), .rst(rst), .run(run), .done(done),
        .flow_in(flow_in), .flow_out(flow_out), .configdata(configdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [BUS_W-1:0] hist [MAXC];

    // model state: one accepted run described by its parameters
    bit                m_active   = 1'b0;
    bit                m_prev_rst = 1'b1;
    int                m_T, m_delay, m_pe, m_iters, m_mode, m_sel, m_end;
    logic [DATA_W-1:0] m_flow = '0;

    // configuration presented on configdata
    int c_sel = 0, c_delay = 0, c_period = 0, c_iters = 0, c_mode = 0;

`ifdef XACCUM_SAT_EN
    localparam logic [31:0] OVF_EXP = 32'h7FFFFFFF;
`else
    localparam logic [31:0] OVF_EXP = 32'h80000000;
`endif

    function automatic logic [31:0] op(input int mode, input logic [31:0] a, input logic [31:0] b);
        longint s;
        case (mode)
            0: begin
`ifdef XACCUM_SAT_EN
                s = longint'($signed(a)) + longint'($signed(b));
                if (s > longint'(2147483647))        return 32'h7FFFFFFF;
                if (s < -longint'(2147483647) - 1)   return 32'h80000000;
                return s[31:0];
`else
                s = 0;
                return a + b;
`endif
            end
            1: return ($signed(a) > $signed(b)) ? a : b;
            2: return ($signed(a) < $signed(b)) ? a : b;
            default: return b;
        endcase
    endfunction

    function automatic logic [31:0] lane(input logic [BUS_W-1:0] w, input int s);
        return w[s*DATA_W +: DATA_W];
    endfunction

    // reduce window k of the active run over the recorded bus history
    function automatic logic [31:0] reduce(input int k);
        int start;
        logic [31:0] acc;
        start = m_T + 1 + m_delay + k*m_pe;
        acc = lane(hist[start], m_sel);
        for (int i = 1; i < m_pe; i++) acc = op(m_mode, acc, lane(hist[start+i], m_sel));
        return acc;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 7))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'($signed($urandom_range(0, 40)) - 20);
            default: return $urandom();
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // one clock: advance the model, compare outputs, then drive this cycle's inputs
    task automatic step(input bit i_run, input bit i_rst, input logic [31:0] x);
        int off;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cycle=%0d actual=over expected=under %0d", cyc, MAXC);
            $fatal(1, "cycle budget exceeded");
        end
        if (m_prev_rst) begin
            m_active = 1'b0;
            m_flow   = '0;
        end else if (m_active) begin
            off = cyc - (m_T + 1 + m_delay);
            if (off > 0 && off % m_pe == 0 && off / m_pe <= m_iters) m_flow = reduce(off/m_pe - 1);
            if (cyc == m_end) m_active = 1'b0;
        end
        chk("flow_out", flow_out, m_flow);
        chk("done", {31'b0, done}, {31'b0, !m_active});

        rst = i_rst;
        run = i_run;
        configdata = {NW'(c_sel), DELAY_W'(c_delay), PERIOD_W'(c_period), PERIOD_W'(c_iters), 2'(c_mode)};
        for (int i = 0; i < BUS_W/32; i++) flow_in[i*32 +: 32] = rnd_word();
        flow_in[c_sel*DATA_W +: DATA_W] = x;
        hist[cyc] = flow_in;
        if (!i_rst && i_run && !m_active && c_iters != 0) begin
            m_active = 1'b1;
            m_T      = cyc;
            m_delay  = c_delay;
            m_pe     = (c_period == 0) ? 1 : c_period;
            m_iters  = c_iters;
            m_mode   = c_mode;
            m_sel    = c_sel;
            m_end    = cyc + 1 + m_delay + m_iters*m_pe;
        end
        m_prev_rst = i_rst;
    endtask

    task automatic set_cfg(input int sel, input int dly, input int per, input int its, input int mode);
        c_sel = sel; c_delay = dly; c_period = per; c_iters = its; c_mode = mode;
    endtask

    initial begin
        int add_v [8] = '{1, 2, 3, 4, 10, 20, 30, 40};
        int max_v [3] = '{-5, 7, -1};
        int min_v [3] = '{4, -2, 9};

        step(0, 1, 0);
        step(0, 1, 0);
        chk("reset_flow", flow_out, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h1);
        step(0, 0, 0);

        // ADD, two windows of four
        set_cfg(3, 0, 4, 2, 0);
        step(1, 0, $urandom());
        for (int i = 0; i < 8; i++) begin
            step(0, 0, add_v[i]);
            if (i == 4) chk("add_win0", flow_out, 32'd10);
            if (i == 7) chk("add_busy", {31'b0, done}, 32'h0);
        end
        step(0, 0, $urandom());
        chk("add_win1", flow_out, 32'd100);
        chk("add_done", {31'b0, done}, 32'h1);

        // MAX with start delay
        set_cfg(5, 2, 3, 1, 1);
        step(1, 0, $urandom());
        step(0, 0, $urandom()); chk("max_busy1", {31'b0, done}, 32'h0);
        step(0, 0, $urandom()); chk("max_busy2", {31'b0, done}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, max_v[i]);
            chk("max_busy", {31'b0, done}, 32'h0);
        end
        step(0, 0, $urandom());
        chk("max_res", flow_out, 32'd7);
        chk("max_done", {31'b0, done}, 32'h1);

        // MIN with period 0, plus an ignored run mid-operation
        set_cfg(0, 0, 0, 3, 2);
        step(1, 0, $urandom());
        step(0, 0, min_v[0]);
        set_cfg(0, 0, 2, 5, 0);
        step(1, 0, min_v[1]);
        chk("min_0", flow_out, 32'd4);
        set_cfg(0, 0, 0, 3, 2);
        step(0, 0, min_v[2]);
        chk("min_1", flow_out, 32'hFFFFFFFE);
        step(0, 0, $urandom());
        chk("min_2", flow_out, 32'd9);
        chk("min_done", {31'b0, done}, 32'h1);
        step(0, 0, $urandom());
        chk("min_ignored", {31'b0, done}, 32'h1);

        // ADD overflow
        set_cfg(15, 0, 2, 1, 0);
        step(1, 0, $urandom());
        step(0, 0, 32'h7FFFFFFF);
        step(0, 0, 32'h1);
        step(0, 0, $urandom());
        chk("add_ovf", flow_out, OVF_EXP);

        // zero iterations: nothing happens
        set_cfg(1, 0, 3, 0, 0);
        step(1, 0, $urandom());
        for (int i = 0; i < 4; i++) begin
            step(0, 0, $urandom());
            chk("it0_done", {31'b0, done}, 32'h1);
            chk("it0_flow", flow_out, OVF_EXP);
        end

        // reset mid-window (with a simultaneous run), then a clean run
        set_cfg(2, 0, 4, 2, 0);
        step(1, 0, $urandom());
        step(0, 0, 32'd5);
        step(0, 0, 32'd6);
        step(1, 1, 32'd7);
        step(0, 0, $urandom());
        chk("rst_flow", flow_out, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h1);
        set_cfg(2, 0, 2, 1, 0);
        step(1, 0, $urandom());
        step(0, 0, 32'd5);
        step(0, 0, 32'd6);
        step(0, 0, $urandom());
        chk("fresh_add", flow_out, 32'd11);

        // randomized phase
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 2) == 0)
                set_cfg($urandom_range(0, 15), $urandom_range(0, 4), $urandom_range(0, 5),
                        $urandom_range(0, 3), $urandom_range(0, 3));
            step($urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0, rnd_word());
        end
        step(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xaccum.md
# xaccum

Windowed stream reducer for the Versat data engine. Consumes one lane of the flow bus, typically an ALU-lite result, and reduces it over a configurable period with ADD, MAX, MIN or LAST. It emits one reduced word per period, for a configurable number of iterations. It sits directly downstream of the ALU units and places its registered result back on the flow bus for later stages.

## Interface
Parameters:
- DATA_W, 32, datapath width; the lane width of flow_in.
- PERIOD_W, 10, width of the period and iterations counters.
- DELAY_W, 8, width of the start-delay counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- run  input  1  one-cycle start pulse; configdata is latched on this cycle.
- done  output  1  high when idle.
- flow_in  input  2*`DATABUS_W  flow bus; the operand lane is picked by sel through xinmux.
- flow_out  output  DATA_W  registered reduced result.
- configdata  input  `N_W+DELAY_W+2*PERIOD_W+2  packed configuration, MSB first: sel[`N_W], delay[DELAY_W], period[PERIOD_W], iterations[PERIOD_W], mode[2].

## Operation
- Modes:
  - 0 ADD: acc + x.
  - 1 MAX: signed maximum.
  - 2 MIN: signed minimum.
  - 3 LAST: x.
- Input select: xinmux on flow_in. The selected operand x is used combinationally; there is no input register. Upstream latency is absorbed through delay.
- State machine:
  - IDLE: done=1. run=1 latches the config into shadow registers.
    - iterations==0: stay IDLE.
    - delay>0: go to DELAY.
    - otherwise: go to ACC.
  - DELAY: down-counts delay cycles, then goes to ACC.
  - ACC: one sample per cycle.
    - Sample counter cnt runs 0..period-1; iteration counter it runs 0..iterations-1.
    - cnt==0: acc_next = x, which restarts the window.
    - Otherwise: acc_next = op(acc, x).
    - cnt==period-1: flow_out <= acc_next, cnt <= 0, it increments.
    - After the last sample of the last iteration: go to IDLE.
- period==0 is treated as 1, so every sample is output through mode op with no history.
- Arithmetic:
  - ADD wraps modulo 2^DATA_W unless saturation is compiled in (see Configuration).
  - MAX/MIN compare signed, using an extended sign bit.
- run is ignored outside IDLE, including on the final ACC cycle.
- configdata changes outside the run cycle have no effect on an operation in progress.
- rst at any time:
  - state goes to IDLE; done=1.
  - flow_out=0; acc=0; all counters=0.
  - Takes priority over run.

## Timing
- Reset values: flow_out=0, done=1.
- run high in cycle T: done=0 from T+1.
- First sample is taken in cycle T+1+delay.
- Window k (0-based) samples cycles T+1+delay+k*period through T+delay+(k+1)*period.
- Window k's result is visible on flow_out from cycle T+1+delay+(k+1)*period and holds until the next window result.
- done returns to 1 in the same cycle as the final flow_out update: T+1+delay+iterations*period.
- A new run is accepted in that same cycle, so back-to-back runs have no gap.
- Throughput: one input per cycle. Latency from last sample to output: 1 cycle.

## Configuration
- XACCUM_SAT_EN
  - Defined: ADD saturates to signed limits, 0x7FFFFFFF and 0x80000000 for DATA_W=32. Overflow is detected from the carry into and out of the MSB.
  - Undefined: ADD wraps. The saturation logic is absent.
  - MAX, MIN and LAST are unaffected either way.

## Test plan
- ADD, delay=0, period=4, iterations=2, lane inputs 1,2,3,4,10,20,30,40 from T+1:
  - flow_out=10 at T+5 and 100 at T+9.
  - done=1 at T+9.
- MAX, delay=2, period=3, iterations=1, inputs -5,7,-1 starting T+3:
  - flow_out=7 at T+6.
  - done low T+1..T+5.
- MIN, period=0, iterations=3, inputs 4,-2,9:
  - flow_out=4, -2, 9 on consecutive cycles.
  - run issued mid-operation is ignored.
- ADD, period=2, inputs 0x7FFFFFFF and 1:
  - without XACCUM_SAT_EN: flow_out=0x80000000.
  - with it: 0x7FFFFFFF.
- iterations=0: done never deasserts; flow_out unchanged.
- rst asserted in ACC mid-window: next cycle flow_out=0, done=1.
  - A run after reset gives a correct fresh result with no stale accumulator.
